// File: rtl/riscv_enc_pkg.sv
// Shared constants for building RV32 instruction words: format codes, opcodes, canonical NOP.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP        = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0]  OPC_LUI    = 7'h37;
  localparam logic [6:0]  OPC_JAL    = 7'h6F;
  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [6:0]  OPC_STORE  = 7'h23;
  localparam logic [6:0]  OPC_BRANCH = 7'h63;

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction-word producer, the encoder and its consumer.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request side and the result side.
interface inst_encoder_if #(
  parameter int IWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [DWIDTH-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [IWIDTH-1:0] out_inst;
  logic              out_err;

  // Producer/consumer side (the environment around the encoder).
  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_pack.sv
// Packs decoded fields into an RV32 word and flags immediates that the format cannot represent.
// Latency: combinational.
// Backpressure: none; sits between the encoder's pipeline registers.
module inst_pack
  import riscv_enc_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DWIDTH-1:0] imm,
  output logic [31:0]       inst,
  output logic              err
);

  // A signed immediate fits in N bits when every bit from N-1 upward is a copy of the sign.
  logic hi11_ok, hi12_ok, hi20_ok, hi31_ok;
  assign hi11_ok = (&imm[DWIDTH-1:11]) || !(|imm[DWIDTH-1:11]);
  assign hi12_ok = (&imm[DWIDTH-1:12]) || !(|imm[DWIDTH-1:12]);
  assign hi20_ok = (&imm[DWIDTH-1:20]) || !(|imm[DWIDTH-1:20]);
  // For a 32-bit immediate this slice is a single bit and is always fine.
  assign hi31_ok = (&imm[DWIDTH-1:31]) || !(|imm[DWIDTH-1:31]);

  logic [31:0] raw;
  logic        bad;

  // Select the bit layout and legality test for the requested format; bad words become a NOP.
  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (fmt)
      FMT_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !hi11_ok;
      end
      FMT_S: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = !hi11_ok;
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = !hi12_ok || imm[0];
      end
      FMT_U: begin
        raw = {imm[31:12], rd, opcode};
        bad = (imm[11:0] != 12'd0) || !hi31_ok;
      end
      FMT_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = !hi20_ok || imm[0];
      end
      default: bad = 1'b1;
    endcase
    inst = bad ? NOP : raw;
    err  = bad;
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage pipelined RV32 instruction encoder with per-format immediate range checking.
// Latency: 2 cycles accept-to-output, 1 word per cycle.
// Backpressure: out_ready low stalls S2 then S1; in_ready depends only on state and out_ready.
module inst_encoder
  import riscv_enc_pkg::*;
#(
  parameter int IWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  inst_encoder_if.slave    bus,
  output logic [CNT_W-1:0] err_count
);

  logic              adv1, adv2;

  logic              s1_valid;
  logic [2:0]        s1_fmt;
  logic [6:0]        s1_opcode;
  logic [4:0]        s1_rd, s1_rs1, s1_rs2;
  logic [2:0]        s1_funct3;
  logic [6:0]        s1_funct7;
  logic [DWIDTH-1:0] s1_imm;

  logic              s2_valid;
  logic [IWIDTH-1:0] s2_inst;
  logic              s2_err;

  logic [31:0]       pack_inst;
  logic              pack_err;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2        = !s2_valid || bus.out_ready;
  assign adv1        = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign bus.out_valid = s2_valid;
  assign bus.out_inst  = s2_inst;
  assign bus.out_err   = s2_err;

  inst_pack #(.DWIDTH(DWIDTH)) u_pack (
    .fmt    (s1_fmt),
    .opcode (s1_opcode),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .funct3 (s1_funct3),
    .funct7 (s1_funct7),
    .imm    (s1_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  // S1: capture the raw request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_fmt    <= bus.in_fmt;
        s1_opcode <= bus.in_opcode;
        s1_rd     <= bus.in_rd;
        s1_rs1    <= bus.in_rs1;
        s1_rs2    <= bus.in_rs2;
        s1_funct3 <= bus.in_funct3;
        s1_funct7 <= bus.in_funct7;
        s1_imm    <= bus.in_imm;
      end
    end
  end

  // S2: hold the packed word; frozen while the consumer stalls so outputs stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_inst  <= '0;
      s2_err   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inst <= pack_inst;
        s2_err  <= pack_err;
      end
    end
  end

  // Count errored words as they are handed to the consumer, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (s2_valid && bus.out_ready && s2_err && !(&err_count)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, error cases, backpressure and mid-flight reset.
// Latency: checks accept-to-output of 2 cycles.
// Backpressure: exercises a 5-cycle consumer stall while streaming.
module tb_inst_encoder;
  import riscv_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] err_count;

  int vec_cnt = 0;
  int miss    = 0;

  inst_encoder_if #(.IWIDTH(32), .DWIDTH(32)) bus ();

  inst_encoder #(.IWIDTH(32), .DWIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic set_req(input vec_t v);
    bus.in_fmt    = v.f;
    bus.in_opcode = v.opc;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
  endtask

  // Send one request with the pipeline idle; report the word, its error flag and the latency
  // in clock edges counted from the accepting edge (99 if a bound expired).
  task automatic issue(input vec_t v, output logic [31:0] inst, output logic err, output int lat);
    int waitc;
    inst = '0;
    err  = 1'b0;
    @(negedge clk);
    set_req(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (waitc >= 20) begin
      bus.in_valid = 1'b0;
      lat = 99;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      lat = 99;
      return;
    end
    inst = bus.out_inst;
    err  = bus.out_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      miss++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    vec_cnt++;
    if (bus.out_inst !== 32'h0) begin
      miss++; $display("FAIL reset_out_inst got=%h want=00000000", bus.out_inst);
    end
    vec_cnt++;
    if (bus.out_err !== 1'b0) begin
      miss++; $display("FAIL reset_out_err got=%b want=0", bus.out_err);
    end
    vec_cnt++;
    if (err_count !== 16'd0) begin
      miss++; $display("FAIL reset_err_count got=%0d want=0", err_count);
    end
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      miss++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_encode();
    vec_t vt [8];
    logic [31:0] inst;
    logic err;
    int lat;
    vt[0] = '{FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093}; // addi x1,x0,-1
    vt[1] = '{FMT_S, OPC_STORE,  5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0021_A423}; // sw x2,8(x3)
    vt[2] = '{FMT_J, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF}; // jal x1,+2048
    vt[3] = '{FMT_U, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7}; // lui x5,0x12345
    vt[4] = '{FMT_R, 7'h33,      5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3}; // add x3,x1,x2
    vt[5] = '{FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3}; // beq x1,x2,-4
    vt[6] = '{FMT_S, OPC_STORE,  5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8021_A023}; // sw x2,-2048(x3)
    vt[7] = '{FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7FF0_0093}; // addi x1,x0,2047
    for (int i = 0; i < 8; i++) begin
      issue(vt[i], inst, err, lat);
      vec_cnt++;
      if (lat !== 2) begin
        miss++; $display("FAIL enc%0d_latency got=%0d want=2", i, lat);
      end
      vec_cnt++;
      if (inst !== vt[i].exp) begin
        miss++; $display("FAIL enc%0d_inst got=%h want=%h", i, inst, vt[i].exp);
      end
      vec_cnt++;
      if (err !== 1'b0) begin
        miss++; $display("FAIL enc%0d_err got=%b want=0", i, err);
      end
    end
    vec_cnt++;
    if (err_count !== 16'd0) begin
      miss++; $display("FAIL enc_err_count got=%0d want=0", err_count);
    end
  endtask

  task automatic test_errors();
    vec_t vt [5];
    logic [31:0] inst;
    logic err;
    int lat;
    vt[0] = '{FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, NOP}; // odd offset
    vt[1] = '{FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, NOP}; // 2048 overflows
    vt[2] = '{3'd7,  OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, NOP}; // illegal format
    vt[3] = '{FMT_J, OPC_JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, NOP}; // odd jump
    vt[4] = '{FMT_U, OPC_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, NOP}; // low bits set
    for (int i = 0; i < 5; i++) begin
      issue(vt[i], inst, err, lat);
      vec_cnt++;
      if (lat !== 2) begin
        miss++; $display("FAIL err%0d_latency got=%0d want=2", i, lat);
      end
      vec_cnt++;
      if (inst !== NOP) begin
        miss++; $display("FAIL err%0d_inst got=%h want=%h", i, inst, NOP);
      end
      vec_cnt++;
      if (err !== 1'b1) begin
        miss++; $display("FAIL err%0d_flag got=%b want=1", i, err);
      end
      vec_cnt++;
      if (err_count !== 16'(i + 1)) begin
        miss++; $display("FAIL err%0d_count got=%0d want=%0d", i, err_count, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    logic [31:0] got [$];
    int          got_cyc [$];
    int          sent = 0;
    logic [31:0] hold_inst = '0;
    logic        hold_err = 1'b0;
    logic        hold_v = 1'b0;
    vec_t        v;
    for (int k = 0; k < 4; k++)
      exp[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (sent < 4) begin
        v = '{FMT_I, OPC_OP_IMM, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1), 32'h0};
        set_req(v);
      end
      bus.in_valid = (sent < 4);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        vec_cnt++;
        if (bus.in_ready !== 1'b0) begin
          miss++; $display("FAIL bp_in_ready_c%0d got=%b want=0", cyc, bus.in_ready);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (hold_v) begin
          vec_cnt++;
          if (bus.out_inst !== hold_inst || bus.out_err !== hold_err) begin
            miss++; $display("FAIL bp_stable_c%0d got=%h/%b want=%h/%b",
                             cyc, bus.out_inst, bus.out_err, hold_inst, hold_err);
          end
        end
        hold_v    = 1'b1;
        hold_inst = bus.out_inst;
        hold_err  = bus.out_err;
      end else begin
        hold_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_inst);
        got_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (cyc == 4) begin
        vec_cnt++;
        if (sent !== 2) begin
          miss++; $display("FAIL bp_accepted got=%0d want=2", sent);
        end
      end
    end
    bus.in_valid = 1'b0;
    vec_cnt++;
    if (got.size() !== 4) begin
      miss++; $display("FAIL bp_out_count got=%0d want=4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      vec_cnt++;
      if (got[k] !== exp[k]) begin
        miss++; $display("FAIL bp_order%0d got=%h want=%h", k, got[k], exp[k]);
      end
      if (k > 0) begin
        vec_cnt++;
        if (got_cyc[k] !== got_cyc[k-1] + 1) begin
          miss++; $display("FAIL bp_gap%0d got=%0d want=%0d", k, got_cyc[k], got_cyc[k-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    logic [31:0] inst;
    logic err;
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    v = '{3'd7, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0};
    set_req(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    v = '{FMT_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5, 32'h0};
    set_req(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    vec_cnt++;
    if (bus.out_valid !== 1'b1) begin
      miss++; $display("FAIL rstmid_inflight got=%b want=1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      miss++; $display("FAIL rstmid_out_valid got=%b want=0", bus.out_valid);
    end
    vec_cnt++;
    if (err_count !== 16'd0) begin
      miss++; $display("FAIL rstmid_err_count got=%0d want=0", err_count);
    end
    vec_cnt++;
    if (bus.out_inst !== 32'h0 || bus.out_err !== 1'b0) begin
      miss++; $display("FAIL rstmid_out got=%h/%b want=00000000/0", bus.out_inst, bus.out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      miss++; $display("FAIL rstmid_dropped got=%b want=0", bus.out_valid);
    end
    v = '{FMT_I, OPC_OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7, 32'h0070_0393};
    issue(v, inst, err, lat);
    vec_cnt++;
    if (lat !== 2) begin
      miss++; $display("FAIL rstmid_latency got=%0d want=2", lat);
    end
    vec_cnt++;
    if (inst !== v.exp || err !== 1'b0) begin
      miss++; $display("FAIL rstmid_inst got=%h/%b want=%h/0", inst, err, v.exp);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_fmt    = '0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
    test_reset();
    test_encode();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule
